// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode map, datapath widths and the memory-stage FSM encoding.
// Small opcode classifiers keep the decode in the stage readable.
package pipeline_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_MUL = 7'h02;
  localparam logic [6:0] OP_LDW = 7'h10;
  localparam logic [6:0] OP_LDB = 7'h11;
  localparam logic [6:0] OP_STW = 7'h12;
  localparam logic [6:0] OP_STB = 7'h13;
  localparam logic [6:0] OP_NOP = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  function automatic logic is_alu_op(input logic [6:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  function automatic logic is_load_op(input logic [6:0] op);
    return (op == OP_LDW) || (op == OP_LDB);
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return is_load_op(op) || (op == OP_STW) || (op == OP_STB);
  endfunction

  function automatic logic is_byte_op(input logic [6:0] op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit data bus and byte/word accesses:
// store byte enables and data replication, and zero-extended load lane extraction.
module mem_lane_align
  import pipeline_pkg::*;
(
  input  logic              is_byte,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    be        = 4'hF;
    wdata     = store_data;
    load_data = rdata;
    if (is_byte) begin
      be        = 4'b0001 << lane;
      wdata     = {4{store_data[7:0]}};
      load_data = {24'h0, rdata[8*lane +: 8]};
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: registers ALU results for writeback, runs load/store accesses over a
// req/gnt/rvalid handshake with a timeout, and stalls upstream while an access is open.
module memory_access_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [6:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_W-1:0]  ex_dst,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  bp_reg_mem,
  output logic [DATA_W-1:0] bp_data_mem,
  output logic              mem_err
);

  mem_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [REG_W-1:0]  ld_dst_q, ld_dst_d;
  logic              ld_byte_q, ld_byte_d;
  logic [1:0]        lane_q, lane_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_W-1:0]  wb_dst_q, wb_dst_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              mem_err_q, mem_err_d;

  logic              idle, mem_op, misaligned, accept, timeout_hit, load_done, leave;
  logic              align_byte;
  logic [1:0]        align_lane;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata, al_load;

  assign idle        = (state_q == ST_IDLE);
  assign mem_op      = ex_valid && is_mem_op(ex_opcode);
  assign misaligned  = !is_byte_op(ex_opcode) && (ex_result[1:0] != 2'b00);
  assign accept      = idle && mem_op && !misaligned;
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));
  assign load_done   = (state_q == ST_REQ && dmem_gnt && !we_q && dmem_rvalid) ||
                       (state_q == ST_WAIT && dmem_rvalid);

  // One aligner serves both directions: in IDLE it shapes the incoming store,
  // while busy it extracts the lane of the load that is in flight.
  assign align_byte = idle ? is_byte_op(ex_opcode) : ld_byte_q;
  assign align_lane = idle ? ex_result[1:0] : lane_q;

  mem_lane_align u_align (
    .is_byte    (align_byte),
    .lane       (align_lane),
    .store_data (ex_store_data),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ld_dst_d   = ld_dst_q;
    ld_byte_d  = ld_byte_q;
    lane_d     = lane_q;
    wb_valid_d = 1'b0;
    wb_dst_d   = wb_dst_q;
    wb_data_d  = wb_data_q;
    mem_err_d  = mem_err_q;
    leave      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid && is_alu_op(ex_opcode) && ex_dst != '0) begin
          wb_valid_d = 1'b1;
          wb_dst_d   = ex_dst;
          wb_data_d  = ex_result;
        end else if (mem_op && misaligned) begin
          mem_err_d = 1'b1;
        end else if (accept) begin
          state_d   = ST_REQ;
          req_d     = 1'b1;
          we_d      = !is_load_op(ex_opcode);
          addr_d    = {ex_result[DATA_W-1:2], 2'b00};
          be_d      = al_be;
          wdata_d   = al_wdata;
          ld_dst_d  = ex_dst;
          ld_byte_d = is_byte_op(ex_opcode);
          lane_d    = ex_result[1:0];
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          req_d = 1'b0;
          if (we_q || dmem_rvalid) begin
            state_d = ST_IDLE;
            leave   = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (timeout_hit) begin
          req_d     = 1'b0;
          state_d   = ST_IDLE;
          mem_err_d = 1'b1;
          leave     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          state_d = ST_IDLE;
          leave   = 1'b1;
        end else if (timeout_hit) begin
          state_d   = ST_IDLE;
          mem_err_d = 1'b1;
          leave     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_done) begin
      wb_valid_d = (ld_dst_q != '0);
      wb_dst_d   = ld_dst_q;
      wb_data_d  = al_load;
    end

    cnt_d = (idle || state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      ld_dst_q   <= '0;
      ld_byte_q  <= 1'b0;
      lane_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_dst_q   <= '0;
      wb_data_q  <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      ld_dst_q   <= ld_dst_d;
      ld_byte_q  <= ld_byte_d;
      lane_q     <= lane_d;
      wb_valid_q <= wb_valid_d;
      wb_dst_q   <= wb_dst_d;
      wb_data_q  <= wb_data_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Stall releases in the completing cycle so upstream advances on the same edge we return to IDLE.
  assign stall       = (!idle && !leave) || accept;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_dst      = wb_dst_q;
  assign wb_data     = wb_data_q;
  assign bp_reg_mem  = wb_valid_q ? wb_dst_q  : '0;
  assign bp_data_mem = wb_valid_q ? wb_data_q : '0;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios, then a randomized instruction stream
// checked by writeback and bus-request scoreboards against a word-level memory model.
module tb_memory_access_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_dst;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, wb_valid, mem_err;
  logic [4:0]  wb_dst, bp_reg_mem;
  logic [31:0] wb_data, bp_data_mem;

  logic        auto_resp;
  logic        a_gnt, a_rvalid, m_gnt, m_rvalid;
  logic [31:0] a_rdata, m_rdata;

  assign dmem_gnt    = auto_resp ? a_gnt    : m_gnt;
  assign dmem_rvalid = auto_resp ? a_rvalid : m_rvalid;
  assign dmem_rdata  = auto_resp ? a_rdata  : m_rdata;

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
    .ex_dst(ex_dst), .ex_store_data(ex_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall(stall), .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .bp_reg_mem(bp_reg_mem), .bp_data_mem(bp_data_mem), .mem_err(mem_err)
  );

  typedef struct { logic [4:0] dst; logic [31:0] data; } wb_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;

  wb_t         exp_wb[$];
  req_t        exp_req[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Unwritten words read back as a fixed hash of their address.
  function automatic logic [31:0] init_word(input logic [31:0] waddr);
    return (waddr * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] waddr);
    return ref_mem.exists(waddr) ? ref_mem[waddr] : init_word(waddr);
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] waddr);
    return slv_mem.exists(waddr) ? slv_mem[waddr] : init_word(waddr);
  endfunction

  task automatic drive(input logic v, input logic [6:0] op, input logic [31:0] res,
                       input logic [4:0] dst, input logic [31:0] sd);
    ex_valid = v; ex_opcode = op; ex_result = res; ex_dst = dst; ex_store_data = sd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, OP_NOP, 32'h0, 5'd0, 32'h0);
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; auto_resp = 1'b0;
    exp_wb.delete(); exp_req.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Writeback monitor: every cycle either pops an expected entry or checks the bypass is quiet.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (exp_wb.size() == 0) begin
          check("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          wb_t e;
          e = exp_wb.pop_front();
          check("wb_dst", 32'(wb_dst), 32'(e.dst));
          check("wb_data", wb_data, e.data);
          check("bp_reg", 32'(bp_reg_mem), 32'(e.dst));
          check("bp_data", bp_data_mem, e.data);
        end
      end else begin
        check("bp_reg_idle", 32'(bp_reg_mem), 32'd0);
        check("bp_data_idle", bp_data_mem, 32'd0);
      end
    end
  end

  // Random memory slave: grants after random delays, answers loads 0..2 cycles after grant.
  initial begin
    logic        pend;
    int          dly;
    logic [31:0] pdata, w;
    req_t        r;
    pend = 1'b0; dly = 0; pdata = 32'h0;
    a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      a_gnt = 1'b0; a_rvalid = 1'b0;
      if (!auto_resp) begin
        pend = 1'b0;
      end else if (pend) begin
        if (dly == 0) begin
          a_rvalid = 1'b1; a_rdata = pdata; pend = 1'b0;
        end else begin
          dly--;
        end
      end else if (dmem_req && $urandom_range(0, 2) != 0) begin
        a_gnt = 1'b1;
        if (exp_req.size() == 0) begin
          check("req_unexpected", 32'(dmem_req), 32'd0);
        end else begin
          r = exp_req.pop_front();
          check("req_we", 32'(dmem_we), 32'(r.we));
          check("req_addr", dmem_addr, r.addr);
          if (r.we) begin
            check("req_be", 32'(dmem_be), 32'(r.be));
            check("req_wdata", dmem_wdata, r.wdata);
          end
        end
        if (dmem_we) begin
          w = slv_read(dmem_addr >> 2);
          for (int b = 0; b < 4; b++)
            if (dmem_be[b]) w[8*b +: 8] = dmem_wdata[8*b +: 8];
          slv_mem[dmem_addr >> 2] = w;
        end else begin
          pdata = slv_read(dmem_addr >> 2);
          dly = $urandom_range(0, 2);
          if (dly == 0) begin
            a_rvalid = 1'b1; a_rdata = pdata;
          end else begin
            pend = 1'b1; dly--;
          end
        end
      end
    end
  end

  task automatic rand_issue();
    logic        v;
    logic [6:0]  op;
    logic [31:0] res, sd, w, wa;
    logic [4:0]  dst;
    logic [1:0]  lane;
    int          k, n;
    v    = ($urandom_range(0, 9) != 0);
    k    = $urandom_range(0, 9);
    dst  = 5'($urandom_range(0, 31));
    sd   = $urandom;
    res  = $urandom;
    lane = 2'd0;
    case (k)
      0: op = OP_ADD;
      1: op = OP_SUB;
      2: op = OP_MUL;
      3: op = OP_NOP;
      4, 5: op = OP_LDW;
      6: op = OP_LDB;
      7: op = OP_STW;
      8: op = OP_STB;
      default: op = 7'h05;
    endcase
    if (k >= 4 && k <= 8) begin
      if (op == OP_LDB || op == OP_STB) lane = 2'($urandom_range(0, 3));
      res = 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'(lane);
    end
    wa = res >> 2;
    if (v) begin
      if (k <= 2) begin
        if (dst != 5'd0) exp_wb.push_back('{dst, res});
      end else if (op == OP_LDW || op == OP_LDB) begin
        w = ref_read(wa);
        if (op == OP_LDB) w = (w >> (8 * lane)) & 32'hFF;
        if (dst != 5'd0) exp_wb.push_back('{dst, w});
        exp_req.push_back('{1'b0, wa << 2, 4'h0, 32'h0});
      end else if (op == OP_STW) begin
        ref_mem[wa] = sd;
        exp_req.push_back('{1'b1, wa << 2, 4'hF, sd});
      end else if (op == OP_STB) begin
        w = ref_read(wa);
        w = (w & ~(32'hFF << (8 * lane))) | ((sd & 32'hFF) << (8 * lane));
        ref_mem[wa] = w;
        exp_req.push_back('{1'b1, wa << 2, 4'b0001 << lane, {4{sd[7:0]}}});
      end
    end
    @(posedge clk);
    #1;
    drive(v, op, res, dst, sd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 500);
    if (stall) check("stall_bound", 32'(stall), 32'd0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    drive(1'b0, OP_NOP, 32'h0, 5'd0, 32'h0);
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; auto_resp = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_bp_reg", 32'(bp_reg_mem), 32'd0);
    check("rst_bp_data", bp_data_mem, 32'd0);
    do_reset();

    // ADD: one-cycle writeback, no stall
    @(posedge clk); #1;
    drive(1'b1, OP_ADD, 32'h7, 5'd3, 32'h0);
    exp_wb.push_back('{5'd3, 32'h7});
    @(negedge clk); check("add_stall", 32'(stall), 32'd0);
    @(posedge clk); #1; ex_valid = 1'b0;
    @(negedge clk); check("add_wb_valid", 32'(wb_valid), 32'd1);

    // LDW 0x100: gnt in REQ, rvalid next cycle
    @(posedge clk); #1;
    drive(1'b1, OP_LDW, 32'h100, 5'd5, 32'h0);
    exp_wb.push_back('{5'd5, 32'hDEAD_BEEF});
    @(negedge clk); check("ldw_stall_accept", 32'(stall), 32'd1);
    check("ldw_no_req_yet", 32'(dmem_req), 32'd0);
    @(posedge clk); #1; m_gnt = 1'b1;
    @(negedge clk); check("ldw_req", 32'(dmem_req), 32'd1);
    check("ldw_addr", dmem_addr, 32'h100);
    check("ldw_we", 32'(dmem_we), 32'd0);
    check("ldw_stall_req", 32'(stall), 32'd1);
    @(posedge clk); #1; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk); check("ldw_stall_rvalid", 32'(stall), 32'd0);
    check("ldw_req_dropped", 32'(dmem_req), 32'd0);
    @(posedge clk); #1; m_rvalid = 1'b0; ex_valid = 1'b0;
    @(negedge clk); check("ldw_wb_valid", 32'(wb_valid), 32'd1);
    @(negedge clk); check("ldw_wb_pulse", 32'(wb_valid), 32'd0);

    // STB 0x203 data 0x55
    @(posedge clk); #1;
    drive(1'b1, OP_STB, 32'h203, 5'd9, 32'h1234_5655);
    @(negedge clk); check("stb_stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1; m_gnt = 1'b1;
    @(negedge clk);
    check("stb_req", 32'(dmem_req), 32'd1);
    check("stb_we", 32'(dmem_we), 32'd1);
    check("stb_addr", dmem_addr, 32'h200);
    check("stb_be", 32'(dmem_be), 32'h8);
    check("stb_wdata", dmem_wdata, 32'h5555_5555);
    check("stb_stall_gnt", 32'(stall), 32'd0);
    @(posedge clk); #1; m_gnt = 1'b0; ex_valid = 1'b0;
    @(negedge clk); check("stb_req_off", 32'(dmem_req), 32'd0);
    check("stb_no_wb", 32'(wb_valid), 32'd0);

    // LDB 0x102 with gnt and rvalid together
    @(posedge clk); #1;
    drive(1'b1, OP_LDB, 32'h102, 5'd7, 32'h0);
    exp_wb.push_back('{5'd7, 32'h0000_00BB});
    @(posedge clk); #1; m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hAABB_CCDD;
    @(negedge clk); check("ldb_stall", 32'(stall), 32'd0);
    check("ldb_be", 32'(dmem_be), 32'h4);
    @(posedge clk); #1; m_gnt = 1'b0; m_rvalid = 1'b0; ex_valid = 1'b0;
    @(negedge clk); check("ldb_wb_valid", 32'(wb_valid), 32'd1);

    // Misaligned LDW 0x101
    @(posedge clk); #1;
    drive(1'b1, OP_LDW, 32'h101, 5'd8, 32'h0);
    @(negedge clk); check("mis_stall", 32'(stall), 32'd0);
    @(posedge clk); #1; ex_valid = 1'b0;
    @(negedge clk); check("mis_no_req", 32'(dmem_req), 32'd0);
    check("mis_err", 32'(mem_err), 32'd1);
    check("mis_no_wb", 32'(wb_valid), 32'd0);

    // Grant never arrives: timeout
    do_reset();
    @(posedge clk); #1;
    drive(1'b1, OP_LDW, 32'h100, 5'd4, 32'h0);
    @(posedge clk); #1; ex_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dmem_req) cnt++;
      else break;
    end
    check("to_req_cycles", 32'(cnt), 32'd255);
    check("to_err", 32'(mem_err), 32'd1);
    check("to_stall", 32'(stall), 32'd0);
    @(posedge clk); #1; m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
    @(posedge clk); #1; m_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("to_late_rvalid_no_wb", 32'(exp_wb.size()), 32'd0);

    // Reset while in WAIT, then while in REQ
    do_reset();
    @(posedge clk); #1;
    drive(1'b1, OP_LDW, 32'h100, 5'd6, 32'h0);
    @(posedge clk); #1; m_gnt = 1'b1;
    @(posedge clk); #1; m_gnt = 1'b0;
    @(negedge clk); check("rw_stall_wait", 32'(stall), 32'd1);
    #2; rst_n = 1'b0; ex_valid = 1'b0;
    #1; check("rw_stall_reset", 32'(stall), 32'd0);
    check("rw_req_reset", 32'(dmem_req), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; m_rvalid = 1'b1; m_rdata = 32'h3333_4444;
    @(posedge clk); #1; m_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("rw_mem_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1;
    drive(1'b1, OP_STW, 32'h104, 5'd0, 32'h5);
    @(posedge clk); #1; ex_valid = 1'b0;
    @(negedge clk); check("rr_req_before", 32'(dmem_req), 32'd1);
    #2; rst_n = 1'b0;
    #1; check("rr_req_reset", 32'(dmem_req), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Randomized stream
    do_reset();
    ref_mem.delete(); slv_mem.delete();
    auto_resp = 1'b1;
    for (int i = 0; i < 400; i++) rand_issue();
    @(posedge clk); #1; ex_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("rand_wb_drained", 32'(exp_wb.size()), 32'd0);
    check("rand_req_drained", 32'(exp_req.size()), 32'd0);
    check("rand_no_err", 32'(mem_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
